// File: rtl/carus_banked_sram_ctrl.sv
// Multi-bank SRAM controller for the Carus NMC memory: one request port fanned out to
// NUM_BANKS macros, one-cycle read response, and a retention/wake power-management FSM.
module carus_banked_sram_ctrl #(
  parameter int NUM_BANKS     = 4,
  parameter int BANK_WORDS    = 512,
  parameter int DATA_WIDTH    = 32,
  parameter int INTERLEAVED   = 0,
  parameter int WAKEUP_CYCLES = 8,
  localparam int AddrWidth    = $clog2(NUM_BANKS * BANK_WORDS),
  localparam int BankAw       = $clog2(BANK_WORDS),
  localparam int SelW         = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  localparam int BeW          = DATA_WIDTH / 8
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            req_i,
  output logic                            gnt_o,
  input  logic                            we_i,
  input  logic [AddrWidth-1:0]            addr_i,
  input  logic [DATA_WIDTH-1:0]           wdata_i,
  input  logic [BeW-1:0]                  be_i,
  output logic                            rvalid_o,
  output logic [DATA_WIDTH-1:0]           rdata_o,
  output logic                            err_o,
  input  logic                            ret_req_i,
  output logic                            ret_ack_o,
  output logic [NUM_BANKS-1:0]            bank_req_o,
  output logic                            bank_we_o,
  output logic [BankAw-1:0]               bank_addr_o,
  output logic [DATA_WIDTH-1:0]           bank_wdata_o,
  output logic [BeW-1:0]                  bank_be_o,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] bank_rdata_i,
  output logic [NUM_BANKS-1:0]            bank_set_retentive_no
);

  localparam int WakeLoad = (WAKEUP_CYCLES > 1) ? (WAKEUP_CYCLES - 1) : 0;
  localparam int CntW     = (WakeLoad > 0) ? $clog2(WakeLoad + 1) : 1;

  typedef enum logic [1:0] {
    ST_ACTIVE,
    ST_DRAIN,
    ST_RETENTION,
    ST_WAKE
  } state_e;

  state_e                r_state;
  state_e                w_state_next;
  logic [CntW-1:0]       r_wake_cnt;
  logic [CntW-1:0]       w_wake_cnt_next;

  logic [SelW-1:0]       w_sel;
  logic [BankAw-1:0]     w_bank_addr;
  logic                  w_oor;
  logic                  w_gnt;
  logic                  w_bank_go;

  logic                  r_rvalid;
  logic                  r_err;
  logic                  r_rd;
  logic [SelW-1:0]       r_sel;
  logic [DATA_WIDTH-1:0] r_rdata_hold;
  logic [DATA_WIDTH-1:0] w_slice;
  logic [DATA_WIDTH-1:0] w_rdata;

  // Address decode; only a non-power-of-2 contiguous map can fall off the end.
  if (NUM_BANKS == 1) begin : g_single
    assign w_sel       = '0;
    assign w_bank_addr = addr_i[BankAw-1:0];
    assign w_oor       = 1'b0;
  end else if (INTERLEAVED != 0) begin : g_interleaved
    assign w_sel       = addr_i[SelW-1:0];
    assign w_bank_addr = addr_i[AddrWidth-1:SelW];
    assign w_oor       = 1'b0;
  end else begin : g_contiguous
    localparam logic [AddrWidth:0] Limit = (AddrWidth + 1)'(NUM_BANKS * BANK_WORDS);
    assign w_sel       = addr_i[AddrWidth-1:BankAw];
    assign w_bank_addr = addr_i[BankAw-1:0];
    assign w_oor       = ({1'b0, addr_i} >= Limit);
  end

  assign w_gnt     = req_i & (r_state == ST_ACTIVE) & ~ret_req_i & ~rst_i;
  assign w_bank_go = w_gnt & ~w_oor;
  assign gnt_o     = w_gnt;

  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank_sel
    assign bank_req_o[gi] = w_bank_go & (w_sel == SelW'(gi));
  end

  assign bank_we_o    = w_bank_go & we_i;
  assign bank_addr_o  = w_bank_go ? w_bank_addr : '0;
  assign bank_wdata_o = w_bank_go ? wdata_i     : '0;
  assign bank_be_o    = w_bank_go ? be_i        : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rvalid     <= 1'b0;
      r_err        <= 1'b0;
      r_rd         <= 1'b0;
      r_sel        <= '0;
      r_rdata_hold <= '0;
    end else begin
      r_rvalid <= w_gnt;
      r_err    <= w_gnt & w_oor;
      r_rd     <= w_bank_go & ~we_i;
      if (w_gnt) begin
        r_sel <= w_sel;
      end
      if (r_rvalid) begin
        r_rdata_hold <= w_rdata;
      end
    end
  end

  // The macros register their read data, so the slice is valid in the response cycle.
  always_comb begin
    w_slice = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (r_sel == SelW'(b)) begin
        w_slice = bank_rdata_i[b*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_rdata  = r_rvalid ? (r_rd ? w_slice : '0) : r_rdata_hold;
  assign rdata_o  = w_rdata;
  assign rvalid_o = r_rvalid;
  assign err_o    = r_err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= ST_ACTIVE;
      r_wake_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_wake_cnt <= w_wake_cnt_next;
    end
  end

  always_comb begin
    w_state_next          = r_state;
    w_wake_cnt_next       = r_wake_cnt;
    ret_ack_o             = 1'b0;
    bank_set_retentive_no = '1;
    case (r_state)
      ST_ACTIVE: begin
        if (ret_req_i) begin
          w_state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        w_state_next = ST_RETENTION;
      end
      ST_RETENTION: begin
        ret_ack_o             = 1'b1;
        bank_set_retentive_no = '0;
        if (!ret_req_i) begin
          w_state_next    = ST_WAKE;
          w_wake_cnt_next = CntW'(WakeLoad);
        end
      end
      ST_WAKE: begin
        if (r_wake_cnt == '0) begin
          w_state_next = ST_ACTIVE;
        end else begin
          w_wake_cnt_next = r_wake_cnt - 1'b1;
        end
      end
      default: begin
        w_state_next = ST_ACTIVE;
      end
    endcase
  end

endmodule

// File: doc/carus_banked_sram_ctrl.md
Name: carus_banked_sram_ctrl

Overview:
Parametrised multi-bank SRAM controller for the Carus NMC memory, successor to the single-bank SRAM wrapper. It maps one request port onto NUM_BANKS generated SRAM macros using contiguous or word-interleaved address decode, with byte enables and a one-cycle read response. It adds a retention power-management FSM with a request/acknowledge handshake and a wake-up counter. It sits between the Carus bus adapter and the per-bank sram_wrapper instances.

Parameters:
NUM_BANKS, 4, number of SRAM macros; 1..16; must be a power of 2 when INTERLEAVED=1.
BANK_WORDS, 512, words per bank; power of 2.
DATA_WIDTH, 32, word width; multiple of 8.
INTERLEAVED, 0, 0 = bank from high address bits (contiguous); 1 = bank from low address bits.
WAKEUP_CYCLES, 8, cycles to hold off access after leaving retention; effective minimum 1.
Derived (not overridable): AddrWidth = clog2(NUM_BANKS*BANK_WORDS), BankAw = clog2(BANK_WORDS), SelW = max(1, clog2(NUM_BANKS)).

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
req_i  in  1  access request
gnt_o  out  1  request accepted this cycle
we_i  in  1  1 = write, 0 = read
addr_i  in  AddrWidth  word address
wdata_i  in  DATA_WIDTH  write data
be_i  in  DATA_WIDTH/8  byte enables
rvalid_o  out  1  response valid, one per grant
rdata_o  out  DATA_WIDTH  read data
err_o  out  1  out-of-range access, qualified by rvalid_o
ret_req_i  in  1  level request to enter retention
ret_ack_o  out  1  all banks retentive
bank_req_o  out  NUM_BANKS  one-hot bank select
bank_we_o  out  1  shared write enable
bank_addr_o  out  BankAw  shared in-bank address
bank_wdata_o  out  DATA_WIDTH  shared write data
bank_be_o  out  DATA_WIDTH/8  shared byte enables
bank_rdata_i  in  NUM_BANKS*DATA_WIDTH  bank read data; bank b occupies bits [b*DATA_WIDTH +: DATA_WIDTH]
bank_set_retentive_no  out  NUM_BANKS  per-bank retention control, active-low

Behaviour:
- Reset: FSM=ACTIVE; gnt_o, rvalid_o, err_o, ret_ack_o, bank_req_o = 0; rdata_o = 0; bank_set_retentive_no = all 1s; wake counter = 0. Reset asserted in any state, including RETENTION, returns the block to ACTIVE immediately.
- Decode: INTERLEAVED=0: bank = addr_i / BANK_WORDS, in-bank address = addr_i mod BANK_WORDS. INTERLEAVED=1: bank = addr_i[SelW-1:0], in-bank address = addr_i >> SelW.
- Range check: address >= NUM_BANKS*BANK_WORDS, possible only for a non-power-of-2 NUM_BANKS, is out of range. Such a request is granted, drives no bank_req_o, and returns rvalid_o=1, err_o=1, rdata_o=0. Writes to out-of-range addresses are dropped.
- Grant: gnt_o = req_i & (state==ACTIVE) & ~ret_req_i; purely combinational. Bank outputs mirror the request in the grant cycle; bank_req_o is all zero when there is no grant.
- Response: rvalid_o is registered and asserted exactly one cycle after each grant; back-to-back grants give back-to-back rvalid_o.
  - Read: rdata_o = bank_rdata_i slice of the bank index registered in the grant cycle.
  - Write: rdata_o = 0, err_o = 0 unless out of range.
  - rdata_o holds its last value while rvalid_o = 0.
- FSM:
  - ACTIVE: if ret_req_i, go to DRAIN.
  - DRAIN: one cycle; the outstanding rvalid_o, if any, completes; no grant; go to RETENTION.
  - RETENTION: bank_set_retentive_no = all 0; ret_ack_o = 1; no grant. When ret_req_i falls, go to WAKE and load counter = max(WAKEUP_CYCLES,1) - 1.
  - WAKE: bank_set_retentive_no = all 1; ret_ack_o = 0; no grant; counter decrements; go to ACTIVE when counter == 0.
- ret_req_i dropping during DRAIN: complete the DRAIN -> RETENTION -> WAKE sequence anyway; do not abort mid-transition.
- ret_req_i rising during WAKE: finish WAKE, enter ACTIVE, then re-enter DRAIN on the next cycle.
- req_i held while not ACTIVE: no grant and no response; the request stays pending for the master.
- bank_we_o, bank_addr_o, bank_wdata_o, bank_be_o are don't-care when bank_req_o = 0 and are driven 0.

Test Plan:
- Contiguous, defaults: write 0xDEADBEEF at addr 0x205 with be=0xF, then read 0x205 -> bank_req_o=0b0010, bank_addr_o=0x005; read returns rvalid_o one cycle after gnt_o with rdata_o=0xDEADBEEF.
- INTERLEAVED=1: reads at addr 4, 5, 6, 7 back-to-back -> bank_req_o = 0001, 0010, 0100, 1000 with bank_addr_o=1 each; four consecutive rvalid_o, each carrying the correct bank slice.
- Byte enables: write 0x11223344 with be=0b0101 -> bank_be_o=0b0101 passed through unchanged in the grant cycle.
- NUM_BANKS=3, BANK_WORDS=512: read at addr 0x600 -> gnt_o=1, no bank_req_o, next cycle rvalid_o=1, err_o=1, rdata_o=0.
- Retention: assert ret_req_i one cycle after a read grant -> read response still delivered, DRAIN for 1 cycle, then bank_set_retentive_no=0, ret_ack_o=1. Drop ret_req_i -> no grant for exactly 8 cycles, then gnt_o follows req_i.
- Assert rst_i while in RETENTION -> next edge gives ret_ack_o=0 and bank_set_retentive_no=all 1; after release, a pending req_i is granted immediately.
